// File: rtl/leak_pkg.sv
// Shared constants for the multiplier leak monitor: FSM encoding and default sizing.
package leak_pkg;

  localparam int unsigned DEFAULT_CNT_W   = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

endpackage

// File: rtl/multiplier_leak_monitor_if.sv
// Run request / per-channel done inputs and result outputs of the leak monitor.
// LEAK_LATENCY_REPORT_EN adds the per-channel latency bus.
interface multiplier_leak_monitor_if
  import leak_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
);

  logic              start;
  logic [NUM_CH-1:0] productDone;
  logic              timingLeak;
  logic              timingLeakDone;
  logic [NUM_CH-1:0] lateMask;
  logic [CNT_W-1:0]  firstLatency;
  logic              timeout;
  logic              busy;
`ifdef LEAK_LATENCY_REPORT_EN
  logic [NUM_CH*CNT_W-1:0] latencyBus;

  modport master (
    output start, productDone,
    input  timingLeak, timingLeakDone, lateMask, firstLatency, timeout, busy, latencyBus
  );
  modport slave (
    input  start, productDone,
    output timingLeak, timingLeakDone, lateMask, firstLatency, timeout, busy, latencyBus
  );
`else
  modport master (
    output start, productDone,
    input  timingLeak, timingLeakDone, lateMask, firstLatency, timeout, busy
  );
  modport slave (
    input  start, productDone,
    output timingLeak, timingLeakDone, lateMask, firstLatency, timeout, busy
  );
`endif

endinterface

// File: rtl/leak_lane.sv
// One monitored channel: first-done capture, late flag, and (LEAK_LATENCY_REPORT_EN) latency.
module leak_lane
  import leak_pkg::*;
`ifdef LEAK_LATENCY_REPORT_EN
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             capture_en_i,
  input  logic             done_i,
  input  logic             prior_first_i,
  input  logic             abort_i,
`ifdef LEAK_LATENCY_REPORT_EN
  input  logic [CNT_W-1:0] lat_i,
  output logic [CNT_W-1:0] latency_o,
`endif
  output logic             hit_c,
  output logic             seen_c,
  output logic             late_c
);

  logic seen_q;
  logic late_q;

  // Kept as separate assigns: abort_i is derived from every lane's seen_c.
  assign hit_c  = capture_en_i & done_i & ~seen_q;
  assign seen_c = ~clear_i & (seen_q | hit_c);
  assign late_c = ~clear_i & (late_q | (hit_c & prior_first_i) | (abort_i & ~seen_q & ~hit_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 1'b0;
      late_q <= 1'b0;
    end else begin
      seen_q <= seen_c;
      late_q <= late_c;
    end
  end

`ifdef LEAK_LATENCY_REPORT_EN
  logic [CNT_W-1:0] latency_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latency_q <= '0;
    end else if (clear_i) begin
      latency_q <= '0;
    end else if (hit_c) begin
      latency_q <= lat_i;
    end
  end

  assign latency_o = latency_q;
`endif

endmodule

// File: rtl/multiplier_leak_monitor.sv
// Detects data-dependent completion timing across multipliers sharing one start pulse.
// Optional feature macro: LEAK_LATENCY_REPORT_EN (per-channel latency bus).
module multiplier_leak_monitor
  import leak_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  multiplier_leak_monitor_if.slave   bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc_c;

  logic               first_seen_q;
  logic [CNT_W-1:0]   first_lat_q;
  logic [CNT_W-1:0]   first_lat_d;

  logic               leak_q;
  logic               report_q;
  logic [NUM_CH-1:0]  late_mask_q;
  logic [CNT_W-1:0]   first_lat_out_q;
  logic               timeout_q;
  logic               busy_q;

  logic [NUM_CH-1:0]  hit_c, seen_c, late_c;
  logic               clear_c, run_c, all_seen_c, any_hit_c, at_limit_c, finish_c, abort_c;

  assign clear_c    = (state_q == ST_IDLE) & bus.start;
  assign run_c      = (state_q == ST_RUN);
  assign cnt_inc_c  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign all_seen_c = &seen_c;
  assign any_hit_c  = |hit_c;
  assign at_limit_c = (cnt_inc_c == CNT_W'(TIMEOUT));
  assign finish_c   = run_c & (all_seen_c | at_limit_c);
  // Finishing on the timeout edge is still a clean finish.
  assign abort_c    = run_c & at_limit_c & ~all_seen_c;
  assign first_lat_d = first_seen_q ? first_lat_q : (any_hit_c ? cnt_inc_c : '0);

`ifdef LEAK_LATENCY_REPORT_EN
  logic [NUM_CH*CNT_W-1:0] lat_bus_w;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
`ifdef LEAK_LATENCY_REPORT_EN
    leak_lane #(.CNT_W(CNT_W)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear_c),
      .capture_en_i  (run_c),
      .done_i        (bus.productDone[i]),
      .prior_first_i (first_seen_q),
      .abort_i       (abort_c),
      .lat_i         (cnt_inc_c),
      .latency_o     (lat_bus_w[i*CNT_W +: CNT_W]),
      .hit_c         (hit_c[i]),
      .seen_c        (seen_c[i]),
      .late_c        (late_c[i])
    );
`else
    leak_lane u_lane (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear_c),
      .capture_en_i  (run_c),
      .done_i        (bus.productDone[i]),
      .prior_first_i (first_seen_q),
      .abort_i       (abort_c),
      .hit_c         (hit_c[i]),
      .seen_c        (seen_c[i]),
      .late_c        (late_c[i])
    );
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc_c;
        if (all_seen_c || at_limit_c) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // First-done tracking and result registers; results load on the RUN->REPORT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_seen_q    <= 1'b0;
      first_lat_q     <= '0;
      leak_q          <= 1'b0;
      report_q        <= 1'b0;
      late_mask_q     <= '0;
      first_lat_out_q <= '0;
      timeout_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      busy_q   <= (state_d != ST_IDLE);
      report_q <= finish_c;
      if (clear_c) begin
        first_seen_q    <= 1'b0;
        first_lat_q     <= '0;
        leak_q          <= 1'b0;
        late_mask_q     <= '0;
        first_lat_out_q <= '0;
        timeout_q       <= 1'b0;
      end else if (run_c) begin
        if (any_hit_c && !first_seen_q) begin
          first_seen_q <= 1'b1;
          first_lat_q  <= cnt_inc_c;
        end
        if (finish_c) begin
          late_mask_q     <= late_c;
          leak_q          <= |late_c;
          timeout_q       <= abort_c;
          first_lat_out_q <= first_lat_d;
        end
      end
    end
  end

  assign bus.timingLeak     = leak_q;
  assign bus.timingLeakDone = report_q;
  assign bus.lateMask       = late_mask_q;
  assign bus.firstLatency   = first_lat_out_q;
  assign bus.timeout        = timeout_q;
  assign bus.busy           = busy_q;
`ifdef LEAK_LATENCY_REPORT_EN
  assign bus.latencyBus     = lat_bus_w;
`endif

endmodule
